n64a_vtiming: RTL and testbench
===============================

N64A_VTIMING -- requirements
Module: n64a_vtiming

Interface
REQ-001 Parameter LINE_W, default 10, width of line counters (max count 2^LINE_W-1 = 1023).
REQ-002 Parameter PAL_THRES, default 288, field length above which a field is classified PAL.
REQ-003 VCLK  input  1  video clock.
REQ-004 nRST  input  1  reset, asynchronous, active-low.
REQ-005 vdata_valid_i  input  1  one-cycle strobe marking a new demuxed sample.
REQ-006 vdata_sy_i  input  4  sync nibble qualified by vdata_valid_i: [3] nVSYNC, [2] nCLAMP, [1] nHSYNC, [0] nCSYNC.
REQ-007 newline_o  output  1  one-cycle pulse on a detected nHSYNC falling edge.
REQ-008 newframe_o  output  1  one-cycle pulse on a detected nVSYNC falling edge.
REQ-009 line_cnt_o  output  LINE_W  current line number within the field.
REQ-010 palmode_o  output  1  1 = PAL timing, 0 = NTSC timing.
REQ-011 n64_480i_o  output  1  1 = interlaced source.
REQ-012 field_id_o  output  1  field parity; toggles per field only while interlaced.
REQ-013 vinfo_valid_o  output  1  1 = palmode_o, n64_480i_o and field_id_o are locked and trustworthy.

Function
REQ-014 Module shall evaluate inputs only on cycles with vdata_valid_i=1; other cycles shall leave all state unchanged and clear the pulse outputs.
REQ-015 Falling-edge detection: previous-sample register holds vdata_sy_i of the last valid sample; edge = previous bit 1 and current bit 0.
REQ-016 nHSYNC falling edge: line_cnt_o increments, saturating at 1023; newline_o asserted next cycle for exactly one cycle.
REQ-017 nVSYNC falling edge: field length = line_cnt_o latched into last_len, line_cnt_o cleared to 0, newframe_o pulsed one cycle.
REQ-018 Simultaneous H and V edges in one sample: V behaviour wins (line_cnt_o=0), both newline_o and newframe_o pulse.
REQ-019 All outputs registered; latency one VCLK after the qualifying valid sample.
REQ-020 FSM states IDLE, MEAS1, MEAS2, LOCKED.
REQ-021 IDLE -> MEAS1 on first nVSYNC edge (partial field discarded).
REQ-022 MEAS1 -> MEAS2 on next nVSYNC edge, storing len_a.
REQ-023 MEAS2 -> LOCKED on next nVSYNC edge, storing len_b; palmode_o = (len_b > PAL_THRES); n64_480i_o = (|len_a - len_b| == 1); vinfo_valid_o set.
REQ-024 A field length outside [200, 400] at any nVSYNC edge shall force MEAS1 and clear vinfo_valid_o.
REQ-025 LOCKED: each field re-evaluates classification; a change in palmode or interlace class shall force MEAS1 with vinfo_valid_o=0 (outputs hold last values).
REQ-026 Line-counter saturation at 1023 (no vertical sync) shall force IDLE and clear vinfo_valid_o.
REQ-027 field_id_o toggles on every nVSYNC edge while n64_480i_o=1; forced 0 otherwise.
REQ-028 nCLAMP and nCSYNC bits are carried into the previous-sample register but shall not affect state.

Reset
REQ-029 nRST low: state IDLE; all outputs, counters, len registers 0; previous-sample register 4'hF (no spurious edge on first sample).
REQ-030 nRST deasserted mid-field: first valid sample restarts measurement from IDLE; no pulses before the first real edge.

Structure
REQ-031 FSM state encoding and thresholds (200, 400, PAL_THRES) shall live in the shared video-parameter header alongside the sync slice definitions.
REQ-032 Single module; no sub-module required (edge detection is inline).

Verification
REQ-033 NTSC progressive: 4 fields of 263 lines -> vinfo_valid_o=1 after 3rd nVSYNC edge, palmode_o=0, n64_480i_o=0, field_id_o=0.
REQ-034 PAL interlaced: alternating 312/313-line fields -> palmode_o=1, n64_480i_o=1, field_id_o toggling each newframe_o.
REQ-035 Simultaneous H and V falling edge in one sample -> newline_o=newframe_o=1 same cycle, line_cnt_o=0.
REQ-036 Switch from 263-line to 313-line fields while LOCKED -> vinfo_valid_o drops on first 313 field, re-asserts two fields later with palmode_o=1.
REQ-037 nVSYNC held high for 1100 lines -> line_cnt_o saturates at 1023, state IDLE, vinfo_valid_o=0.
REQ-038 nRST pulsed low mid-field while LOCKED -> all outputs 0 immediately; re-lock after three nVSYNC edges.

Source files
------------

// File: rtl/n64a_vtiming_pkg.sv
// n64a_vtiming_pkg: shared video-timing parameters, sync nibble slices and lock FSM states.
package n64a_vtiming_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MEAS1,
        ST_MEAS2,
        ST_LOCKED
    } vt_state_e;

    localparam int SY_NVSYNC = 3;
    localparam int SY_NCLAMP = 2;
    localparam int SY_NHSYNC = 1;
    localparam int SY_NCSYNC = 0;

    // all sync lines inactive, so the first sample after reset cannot see a stale edge
    localparam logic [3:0] SY_IDLE = 4'hF;

    localparam int LEN_MIN       = 200;
    localparam int LEN_MAX       = 400;
    localparam int PAL_THRES_DEF = 288;

    function automatic logic is_adjacent(input logic [15:0] a, input logic [15:0] b);
        return (a > b ? a - b : b - a) == 16'd1;
    endfunction

endpackage

// File: rtl/n64a_vtiming_if.sv
// n64a_vtiming_if: demuxed sync-sample input and timing-info outputs of the vertical timing block.
interface n64a_vtiming_if #(
    parameter int LINE_W = 10
);
    logic              vdata_valid_i;
    logic [3:0]        vdata_sy_i;
    logic              newline_o;
    logic              newframe_o;
    logic [LINE_W-1:0] line_cnt_o;
    logic              palmode_o;
    logic              n64_480i_o;
    logic              field_id_o;
    logic              vinfo_valid_o;

    modport master (
        output vdata_valid_i, vdata_sy_i,
        input  newline_o, newframe_o, line_cnt_o, palmode_o, n64_480i_o, field_id_o, vinfo_valid_o
    );

    modport slave (
        input  vdata_valid_i, vdata_sy_i,
        output newline_o, newframe_o, line_cnt_o, palmode_o, n64_480i_o, field_id_o, vinfo_valid_o
    );
endinterface

// File: rtl/n64a_vtiming.sv
// n64a_vtiming: sync edge detection, line counting and PAL/NTSC/interlace lock from field lengths.
module n64a_vtiming
    import n64a_vtiming_pkg::*;
#(
    parameter int LINE_W    = 10,
    parameter int PAL_THRES = PAL_THRES_DEF
) (
    input logic           VCLK,
    input logic           nRST,
    n64a_vtiming_if.slave vif
);
    localparam logic [LINE_W-1:0] CNT_MAX = '1;
    localparam logic [LINE_W-1:0] CNT_PRE = LINE_W'((1 << LINE_W) - 2);
    localparam logic [LINE_W-1:0] MIN_L   = LINE_W'(LEN_MIN);
    localparam logic [LINE_W-1:0] MAX_L   = LINE_W'(LEN_MAX);
    localparam logic [LINE_W-1:0] PAL_L   = LINE_W'(PAL_THRES);

    vt_state_e         state, state_n;
    logic [3:0]        prev_sy;
    logic [LINE_W-1:0] line_cnt, line_cnt_n, last_len, last_len_n, len_a, len_a_n;
    logic              palmode, palmode_n, n64_480i, n64_480i_n, field_id, field_id_n;
    logic              vinfo, vinfo_n, newline, newframe, lock_now;
    logic              v_edge, h_edge, sat_hit, in_range, pal_new, adj_a, adj_last;
    logic              unused_sy;

    assign v_edge    = vif.vdata_valid_i & prev_sy[SY_NVSYNC] & ~vif.vdata_sy_i[SY_NVSYNC];
    assign h_edge    = vif.vdata_valid_i & prev_sy[SY_NHSYNC] & ~vif.vdata_sy_i[SY_NHSYNC];
    assign sat_hit   = h_edge & ~v_edge & (line_cnt >= CNT_PRE);
    assign in_range  = (line_cnt >= MIN_L) && (line_cnt <= MAX_L);
    assign pal_new   = line_cnt > PAL_L;
    assign adj_a     = is_adjacent(16'(len_a), 16'(line_cnt));
    assign adj_last  = is_adjacent(16'(last_len), 16'(line_cnt));
    assign unused_sy = prev_sy[SY_NCLAMP] ^ prev_sy[SY_NCSYNC];

    always_ff @(posedge VCLK or negedge nRST) begin
        if (!nRST) state <= ST_IDLE;
        else       state <= state_n;
    end

    // a class change while locked drops back to re-measure instead of silently reclassifying
    always_comb begin
        state_n = sat_hit                              ? ST_IDLE   :
                  !v_edge                              ? state     :
                  (state == ST_IDLE || !in_range)      ? ST_MEAS1  :
                  state == ST_MEAS1                    ? ST_MEAS2  :
                  state == ST_MEAS2                    ? ST_LOCKED :
                  (pal_new != palmode || adj_last != n64_480i) ? ST_MEAS1 : ST_LOCKED;
    end

    always_comb begin
        line_cnt_n = v_edge ? '0 : (h_edge && line_cnt != CNT_MAX) ? line_cnt + LINE_W'(1) : line_cnt;
        last_len_n = v_edge ? line_cnt : last_len;
        len_a_n    = (v_edge && in_range && state == ST_MEAS1) ? line_cnt : len_a;
        lock_now   = state == ST_MEAS2 && state_n == ST_LOCKED;
        palmode_n  = lock_now ? pal_new : palmode;
        n64_480i_n = lock_now ? adj_a : n64_480i;
        field_id_n = v_edge ? n64_480i_n & ~field_id : field_id;
        vinfo_n    = state_n == ST_LOCKED;
    end

    always_ff @(posedge VCLK or negedge nRST) begin
        if (!nRST) begin
            prev_sy  <= SY_IDLE;
            line_cnt <= '0;
            last_len <= '0;
            len_a    <= '0;
            palmode  <= 1'b0;
            n64_480i <= 1'b0;
            field_id <= 1'b0;
            vinfo    <= 1'b0;
            newline  <= 1'b0;
            newframe <= 1'b0;
        end else begin
            if (vif.vdata_valid_i) prev_sy <= vif.vdata_sy_i;
            line_cnt <= line_cnt_n;
            last_len <= last_len_n;
            len_a    <= len_a_n;
            palmode  <= palmode_n;
            n64_480i <= n64_480i_n;
            field_id <= field_id_n;
            vinfo    <= vinfo_n;
            newline  <= h_edge;
            newframe <= v_edge;
        end
    end

    assign vif.newline_o     = newline;
    assign vif.newframe_o    = newframe;
    assign vif.line_cnt_o    = line_cnt;
    assign vif.palmode_o     = palmode;
    assign vif.n64_480i_o    = n64_480i;
    assign vif.field_id_o    = field_id;
    assign vif.vinfo_valid_o = vinfo;

endmodule

// File: tb/tb_n64a_vtiming.sv
// tb_n64a_vtiming: directed vector table plus randomized field sequences against a field-history model.
module tb_n64a_vtiming;

    logic VCLK = 1'b0;
    logic nRST = 1'b1;

    n64a_vtiming_if #(.LINE_W(10)) vif();

    n64a_vtiming #(.LINE_W(10), .PAL_THRES(288)) dut (
        .VCLK (VCLK),
        .nRST (nRST),
        .vif  (vif)
    );

    always #5 VCLK = ~VCLK;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic       v;
        logic [3:0] sy;
        logic       nl;
        logic       nf;
        logic [9:0] cnt;
        logic       vi;
    } vec_t;

    vec_t tbl [14];

    logic [3:0] m_prev;
    int         m_cnt;
    bit         m_nl, m_nf, m_pal, m_i, m_fid, m_vi, m_discard;
    int         hist[$];

    function automatic vec_t mk(bit v, logic [3:0] sy, bit nl, bit nf, int cnt);
        return '{v, sy, nl, nf, 10'(cnt), 1'b0};
    endfunction

    function automatic logic [15:0] dut_out();
        return {vif.newline_o, vif.newframe_o, vif.line_cnt_o, vif.palmode_o,
                vif.n64_480i_o, vif.field_id_o, vif.vinfo_valid_o};
    endfunction

    function automatic logic [15:0] model_out();
        return {m_nl, m_nf, 10'(m_cnt), m_pal, m_i, m_fid, m_vi};
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_prev = 4'hF; m_cnt = 0;
        m_nl = 0; m_nf = 0; m_pal = 0; m_i = 0; m_fid = 0; m_vi = 0;
        m_discard = 1;
        hist.delete();
    endtask

    // field boundary: the first one after (re)start is partial, then two good fields classify
    function automatic void field_end(int len);
        bit np, ni;
        if (m_discard) begin
            m_discard = 0;
            hist.delete();
        end else if (len < 200 || len > 400) begin
            hist.delete();
            m_vi = 0;
        end else if (!m_vi) begin
            hist.push_back(len);
            if (hist.size() == 2) begin
                m_pal = len > 288;
                m_i   = (hist[0] - len == 1) || (len - hist[0] == 1);
                m_vi  = 1;
            end
        end else begin
            np = len > 288;
            ni = (hist[$] - len == 1) || (len - hist[$] == 1);
            if (np != m_pal || ni != m_i) begin
                m_vi = 0;
                hist.delete();
            end else begin
                hist.push_back(len);
                void'(hist.pop_front());
            end
        end
        m_fid = m_i ? !m_fid : 1'b0;
    endfunction

    function automatic void model_sample(bit v, logic [3:0] sy);
        bit he, ve;
        m_nl = 0; m_nf = 0;
        if (!v) return;
        he = m_prev[1] && !sy[1];
        ve = m_prev[3] && !sy[3];
        m_prev = sy;
        m_nl = he; m_nf = ve;
        if (ve) begin
            field_end(m_cnt);
            m_cnt = 0;
        end else if (he) begin
            m_cnt = (m_cnt + 1 > 1023) ? 1023 : m_cnt + 1;
            if (m_cnt == 1023) begin
                m_discard = 1;
                m_vi = 0;
            end
        end
    endfunction

    task automatic step(input bit v, input logic [3:0] sy);
        @(negedge VCLK);
        vif.vdata_valid_i = v;
        vif.vdata_sy_i    = sy;
        model_sample(v, sy);
        @(posedge VCLK);
        #1;
        chk("outputs", int'(dut_out()), int'(model_out()));
    endtask

    task automatic send(input logic [3:0] sy);
        if ($urandom_range(0, 7) == 0) step(1'b0, 4'($urandom));
        step(1'b1, sy);
    endtask

    function automatic logic [3:0] sy_of(bit nv, bit nh);
        logic [1:0] r;
        r = 2'($urandom);
        return {nv, r[1], nh, r[0]};
    endfunction

    task automatic field(input int n);
        send(sy_of(1'b0, 1'b1));
        send(sy_of(1'b1, 1'b1));
        repeat (n) begin
            send(sy_of(1'b1, 1'b0));
            send(sy_of(1'b1, 1'b1));
        end
    endtask

    task automatic do_reset();
        @(negedge VCLK);
        vif.vdata_valid_i = 1'b0;
        #2 nRST = 1'b0;
        #1;
        chk("reset_outputs", int'(dut_out()), 0);
        model_reset();
        @(negedge VCLK);
        nRST = 1'b1;
    endtask

    function automatic int len_of(int kind, int j);
        case (kind)
            0:       return 263;
            1:       return 262 + j % 2;
            2:       return 312 + j % 2;
            3:       return (j == 1) ? 150 : 263;
            4:       return $urandom_range(200, 400);
            default: return 450;
        endcase
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL timeout: bench did not reach its summary");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0]  = mk(1, 4'hF, 0, 0, 0);
        tbl[1]  = mk(1, 4'hD, 1, 0, 1);
        tbl[2]  = mk(0, 4'hF, 0, 0, 1);
        tbl[3]  = mk(1, 4'hD, 0, 0, 1);
        tbl[4]  = mk(1, 4'hF, 0, 0, 1);
        tbl[5]  = mk(1, 4'hA, 0, 0, 1);
        tbl[6]  = mk(1, 4'h8, 1, 0, 2);
        tbl[7]  = mk(1, 4'hF, 0, 0, 2);
        tbl[8]  = mk(1, 4'h5, 1, 1, 0);
        tbl[9]  = mk(1, 4'hF, 0, 0, 0);
        tbl[10] = mk(1, 4'hD, 1, 0, 1);
        tbl[11] = mk(0, 4'h5, 0, 0, 1);
        tbl[12] = mk(1, 4'hF, 0, 0, 1);
        tbl[13] = mk(1, 4'h7, 0, 1, 0);

        vif.vdata_valid_i = 1'b0;
        vif.vdata_sy_i    = 4'hF;
        do_reset();

        for (int k = 0; k < 14; k++) begin
            step(tbl[k].v, tbl[k].sy);
            chk($sformatf("vec%0d", k),
                int'({vif.newline_o, vif.newframe_o, vif.line_cnt_o, vif.vinfo_valid_o}),
                int'({tbl[k].nl, tbl[k].nf, tbl[k].cnt, tbl[k].vi}));
        end

        do_reset();
        for (int k = 0; k < 4; k++) begin
            field(263);
            if (k == 1) chk("ntsc_prelock_vinfo", vif.vinfo_valid_o, 0);
            if (k >= 2) chk("ntsc_vinfo", vif.vinfo_valid_o, 1);
        end
        chk("ntsc_pal", vif.palmode_o, 0);
        chk("ntsc_480i", vif.n64_480i_o, 0);
        chk("ntsc_fid", vif.field_id_o, 0);

        for (int k = 0; k < 6; k++) begin
            field((k % 2 == 1) ? 313 : 312);
            if (k == 1) chk("pal_relock_drop", vif.vinfo_valid_o, 0);
            if (k >= 3) begin
                chk("pal_vinfo", vif.vinfo_valid_o, 1);
                chk("pal_mode", vif.palmode_o, 1);
                chk("pal_480i", vif.n64_480i_o, 1);
                chk("pal_fid", vif.field_id_o, k % 2);
            end
        end

        do_reset();
        repeat (4) field(263);
        for (int k = 0; k < 4; k++) begin
            field(313);
            if (k == 0) chk("switch_still_locked", vif.vinfo_valid_o, 1);
            if (k == 1 || k == 2) chk("switch_vinfo_drop", vif.vinfo_valid_o, 0);
        end
        chk("switch_vinfo_back", vif.vinfo_valid_o, 1);
        chk("switch_pal", vif.palmode_o, 1);
        chk("switch_480i", vif.n64_480i_o, 0);

        field(100);
        do_reset();
        for (int k = 0; k < 3; k++) begin
            field(313);
            if (k == 1) chk("rst_relock_wait", vif.vinfo_valid_o, 0);
        end
        chk("rst_relock_vinfo", vif.vinfo_valid_o, 1);
        chk("rst_relock_pal", vif.palmode_o, 1);

        field(1100);
        chk("sat_line_cnt", vif.line_cnt_o, 1023);
        chk("sat_vinfo", vif.vinfo_valid_o, 0);
        repeat (3) field(263);
        chk("sat_relock_vinfo", vif.vinfo_valid_o, 1);
        chk("sat_relock_pal", vif.palmode_o, 0);

        for (int r = 0; r < 6; r++) begin
            int kind;
            kind = $urandom_range(0, 5);
            for (int j = 0; j < 3; j++) field(len_of(kind, j));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
